// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: fetch/data arbiter over a shared word array; define MEM_ARBITER_2P_RR_EN for round-robin ties (else data wins).
module mem_arbiter_2p #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_strb_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        d_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [1:0] state;
  logic [2:0] cnt;
  logic sel_d, we, grant_d, bad, commit;
  logic [3:0] strb;
  logic [31:0] addr, wdata, word;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
`ifdef MEM_ARBITER_2P_RR_EN
  logic last_d;
  always_comb grant_d = d_req_i & (~i_req_i | ~last_d);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) last_d <= 1'b0;
    else if (state == IDLE && (d_req_i || i_req_i)) last_d <= grant_d;
`else
  always_comb grant_d = d_req_i;
`endif
  always_comb begin
    idx = addr[AW+1:2];
    bad = (|addr[1:0]) | (|addr[31:AW+2]);
    commit = state == BUSY && cnt == 3'd0;
    word = mem[idx];
  end
  // array has no reset; the FSM reset keeps commit low, discarding in-flight writes
  always_ff @(posedge clk_i)
    if (commit && sel_d && we && !bad)
      for (int k = 0; k < 4; k++)
        if (strb[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= IDLE;
      cnt <= 3'd0;
      sel_d <= 1'b0;
      we <= 1'b0;
      strb <= 4'h0;
      addr <= 32'h0;
      wdata <= 32'h0;
      i_ack_o <= 1'b0;
      d_ack_o <= 1'b0;
      d_err_o <= 1'b0;
      i_rdata_o <= 32'h0;
      d_rdata_o <= 32'h0;
    end else begin
      i_ack_o <= 1'b0;
      d_ack_o <= 1'b0;
      d_err_o <= 1'b0;
      case (state)
        IDLE: if (d_req_i || i_req_i) begin
          state <= BUSY;
          cnt <= 3'(WAIT_STATES);
          sel_d <= grant_d;
          we <= grant_d & d_we_i;
          strb <= d_strb_i;
          wdata <= d_wdata_i;
          addr <= grant_d ? d_addr_i : i_addr_i;
        end
        BUSY: if (cnt == 3'd0) begin
          state <= RESP;
          if (sel_d) begin
            d_ack_o <= 1'b1;
            d_err_o <= bad;
            d_rdata_o <= bad ? 32'h0 : word;
          end else begin
            i_ack_o <= 1'b1;
            i_rdata_o <= bad ? NOP : word;
          end
        end else cnt <= cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb_mem_arbiter_2p: directed scoreboard bench; instances with WAIT_STATES 1, 0 and 3.
module tb_mem_arbiter_2p;
  typedef struct {
    int p;
    bit is_d;
    bit chk;
    logic [31:0] rdata;
    bit err;
  } exp_t;
  logic clk = 1'b0;
  logic rst [3];
  logic i_req [3], i_ack [3], d_req [3], d_we [3], d_ack [3], d_err [3];
  logic [3:0] d_strb [3];
  logic [31:0] i_addr [3], i_rdata [3], d_addr [3], d_wdata [3], d_rdata [3];
  logic [31:0] last_i [3], last_d [3];
  bit ld_v [3];
  int lat_of [3] = '{4, 3, 6};
  exp_t sbq [$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  mem_arbiter_2p #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_w1 (
    .clk_i(clk), .reset_i(rst[0]), .i_req_i(i_req[0]), .i_addr_i(i_addr[0]),
    .i_rdata_o(i_rdata[0]), .i_ack_o(i_ack[0]), .d_req_i(d_req[0]), .d_we_i(d_we[0]),
    .d_strb_i(d_strb[0]), .d_addr_i(d_addr[0]), .d_wdata_i(d_wdata[0]),
    .d_rdata_o(d_rdata[0]), .d_ack_o(d_ack[0]), .d_err_o(d_err[0]));
  mem_arbiter_2p #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_w0 (
    .clk_i(clk), .reset_i(rst[1]), .i_req_i(i_req[1]), .i_addr_i(i_addr[1]),
    .i_rdata_o(i_rdata[1]), .i_ack_o(i_ack[1]), .d_req_i(d_req[1]), .d_we_i(d_we[1]),
    .d_strb_i(d_strb[1]), .d_addr_i(d_addr[1]), .d_wdata_i(d_wdata[1]),
    .d_rdata_o(d_rdata[1]), .d_ack_o(d_ack[1]), .d_err_o(d_err[1]));
  mem_arbiter_2p #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_w3 (
    .clk_i(clk), .reset_i(rst[2]), .i_req_i(i_req[2]), .i_addr_i(i_addr[2]),
    .i_rdata_o(i_rdata[2]), .i_ack_o(i_ack[2]), .d_req_i(d_req[2]), .d_we_i(d_we[2]),
    .d_strb_i(d_strb[2]), .d_addr_i(d_addr[2]), .d_wdata_i(d_wdata[2]),
    .d_rdata_o(d_rdata[2]), .d_ack_o(d_ack[2]), .d_err_o(d_err[2]));

  task automatic check(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: got %h expected %h", tag, p, obs, exp);
    end
  endtask

  task automatic xact(input int p, input bit is_d, input bit we, input logic [3:0] strb,
                      input logic [31:0] addr, input logic [31:0] wdata, input bit chk,
                      input logic [31:0] exp_rd, input bit exp_err, input string tag);
    int n = 0;
    bit got = 0;
    sbq.push_back('{p, is_d, chk, exp_rd, exp_err});
    @(posedge clk);
    #1;
    if (is_d) begin
      d_req[p] = 1; d_we[p] = we; d_strb[p] = strb; d_addr[p] = addr; d_wdata[p] = wdata;
    end else begin
      i_req[p] = 1; i_addr[p] = addr;
    end
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      got = is_d ? d_ack[p] : i_ack[p];
    end
    check({tag, "_lat"}, p, n, lat_of[p]);
    d_req[p] = 0;
    i_req[p] = 0;
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [3:0] s, input logic [31:0] v, input bit err, input string tag);
    xact(p, 1, 1, s, a, v, err, 32'h0, err, tag);
  endtask
  task automatic rd(input int p, input logic [31:0] a, input logic [31:0] v, input bit err, input string tag);
    xact(p, 1, 0, 4'h0, a, 32'h0, 1, v, err, tag);
  endtask
  task automatic fe(input int p, input logic [31:0] a, input logic [31:0] v, input string tag);
    xact(p, 0, 0, 4'h0, a, 32'h0, 1, v, 0, tag);
  endtask

  // scoreboard monitor: every ack pops one expectation; rdata must hold between acks
  always @(negedge clk)
    for (int p = 0; p < 3; p++)
      if (!rst[p]) begin
        check("err_no_ack", p, d_err[p] & ~d_ack[p], 0);
        if (i_ack[p] || d_ack[p]) begin
          exp_t e;
          check("one_ack", p, i_ack[p] & d_ack[p], 0);
          check("sb_nonempty", p, sbq.size() != 0, 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("ack_inst", p, p, e.p);
            check("ack_is_d", p, d_ack[p], e.is_d);
            if (d_ack[p]) begin
              check("d_err", p, d_err[p], e.err);
              if (e.chk) check("d_rdata", p, d_rdata[p], e.rdata);
              check("i_hold", p, i_rdata[p], last_i[p]);
              last_d[p] = e.rdata;
              ld_v[p] = e.chk;
            end else begin
              check("i_rdata", p, i_rdata[p], e.rdata);
              if (ld_v[p]) check("d_hold", p, d_rdata[p], last_d[p]);
              last_i[p] = e.rdata;
            end
          end
        end else begin
          check("i_idle_hold", p, i_rdata[p], last_i[p]);
          if (ld_v[p]) check("d_idle_hold", p, d_rdata[p], last_d[p]);
        end
      end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t1, n_ack;
    for (int p = 0; p < 3; p++) begin
      rst[p] = 1; i_req[p] = 0; d_req[p] = 0; d_we[p] = 0; d_strb[p] = 0;
      i_addr[p] = 0; d_addr[p] = 0; d_wdata[p] = 0; last_i[p] = 0; last_d[p] = 0; ld_v[p] = 1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      check("rst_acks", p, {i_ack[p], d_ack[p], d_err[p]}, 0);
      check("rst_i_rdata", p, i_rdata[p], 0);
      check("rst_d_rdata", p, d_rdata[p], 0);
      rst[p] = 0;
    end
    // WAIT_STATES=1 instance: basic write/fetch, byte strobes, errors
    wr(0, 32'h10, 4'hF, 32'hDEADBEEF, 0, "wr10");
    fe(0, 32'h10, 32'hDEADBEEF, "fe10");
    wr(0, 32'h20, 4'hF, 32'h11223344, 0, "wr20");
    wr(0, 32'h20, 4'b0101, 32'hAABBCCDD, 0, "wr20_strb");
    rd(0, 32'h20, 32'h11BB33DD, 0, "rd20");
    wr(0, 32'h20, 4'h0, 32'hFFFFFFFF, 0, "wr20_nostrb");
    rd(0, 32'h20, 32'h11BB33DD, 0, "rd20_nostrb");
    rd(0, 32'h22, 32'h0, 1, "rd_misalign");
    rd(0, 32'h1000, 32'h0, 1, "rd_oor");
    wr(0, 32'h1020, 4'hF, 32'hFFFFFFFF, 1, "wr_oor");
    wr(0, 32'h21, 4'hF, 32'hFFFFFFFF, 1, "wr_misalign");
    rd(0, 32'h20, 32'h11BB33DD, 0, "rd20_after_err");
    fe(0, 32'h1000, 32'h00000013, "fe_oor");
    fe(0, 32'h2, 32'h00000013, "fe_misalign");
    wr(0, 32'h100, 4'hF, 32'hA0A0A0A0, 0, "wr100");
    wr(0, 32'h104, 4'hF, 32'hB1B1B1B1, 0, "wr104");
    fe(0, 32'h104, 32'hB1B1B1B1, "fe104");
    // both requests held: last grant was a fetch, so data wins the first tie
`ifdef MEM_ARBITER_2P_RR_EN
    for (int k = 0; k < 4; k++)
      sbq.push_back(k % 2 == 0 ? exp_t'('{0, 1, 1, 32'hA0A0A0A0, 0}) : exp_t'('{0, 0, 1, 32'hB1B1B1B1, 0}));
`else
    for (int k = 0; k < 4; k++) sbq.push_back('{0, 1, 1, 32'hA0A0A0A0, 0});
    sbq.push_back('{0, 0, 1, 32'hB1B1B1B1, 0});
`endif
    @(posedge clk);
    #1;
    d_req[0] = 1; d_we[0] = 0; d_strb[0] = 0; d_addr[0] = 32'h100;
    i_req[0] = 1; i_addr[0] = 32'h104;
    n_ack = 0;
    n = 0;
    while (n_ack < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (d_ack[0] || i_ack[0]) n_ack++;
    end
    check("arb_acks", 0, n_ack, 4);
    d_req[0] = 0;
`ifdef MEM_ARBITER_2P_RR_EN
    i_req[0] = 0;
`else
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_ack[0] && n < 20);
    check("starve_release", 0, i_ack[0], 1);
    i_req[0] = 0;
`endif
    // WAIT_STATES=0 instance: back-to-back fetches with req held
    wr(1, 32'h0, 4'hF, 32'h01010101, 0, "w0_wr0");
    wr(1, 32'h4, 4'hF, 32'h02020202, 0, "w0_wr4");
    rd(1, 32'h40, 32'h0, 1, "w0_rd_oor");
    fe(1, 32'h40, 32'h00000013, "w0_fe_oor");
    sbq.push_back('{1, 0, 1, 32'h01010101, 0});
    sbq.push_back('{1, 0, 1, 32'h02020202, 0});
    @(posedge clk);
    #1;
    i_req[1] = 1; i_addr[1] = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_ack[1] && n < 20);
    t1 = n;
    i_addr[1] = 32'h4;
    do begin
      @(negedge clk);
      n++;
    end while (!i_ack[1] && n < 40);
    check("b2b_gap", 1, n - t1, 3);
    i_req[1] = 0;
    // WAIT_STATES=3 instance: reset in BUSY discards the write
    wr(2, 32'h40, 4'hF, 32'h0, 0, "w3_wr40");
    wr(2, 32'h44, 4'hF, 32'h12345678, 0, "w3_wr44");
    rd(2, 32'h44, 32'h12345678, 0, "w3_rd44");
    fe(2, 32'h44, 32'h12345678, "w3_fe44");
    @(posedge clk);
    #1;
    d_req[2] = 1; d_we[2] = 1; d_strb[2] = 4'hF; d_addr[2] = 32'h40; d_wdata[2] = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst[2] = 1;
    d_req[2] = 0;
    #1;
    check("rst_now_acks", 2, {i_ack[2], d_ack[2], d_err[2]}, 0);
    check("rst_now_i_rdata", 2, i_rdata[2], 0);
    check("rst_now_d_rdata", 2, d_rdata[2], 0);
    last_i[2] = 0;
    last_d[2] = 0;
    ld_v[2] = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[2] = 0;
    rd(2, 32'h40, 32'h0, 0, "w3_rd40_after_rst");
    repeat (3) @(negedge clk);
    check("sb_drained", 0, sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
